// File: rtl/multi_port_register_file.sv
// Multi-ported integer register file with write bypass and a busy scoreboard.
// x0 is hardwired to zero and is never marked busy.
module multi_port_register_file #(
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int BYPASS      = 1,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic [READ_PORTS*AW-1:0]     readAddr,
  output logic [READ_PORTS*XLEN-1:0]   readData,
  output logic [READ_PORTS-1:0]        readBusy,
  input  logic [WRITE_PORTS-1:0]       writeEnable,
  input  logic [WRITE_PORTS*AW-1:0]    writeAddr,
  input  logic [WRITE_PORTS*XLEN-1:0]  writeData,
  input  logic                         issueValid,
  input  logic [AW-1:0]                issueRd,
  input  logic                         flush,
  output logic [NUM_REGS-1:0]          busyVector
);

  logic [XLEN-1:0]     mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < WRITE_PORTS; w++) begin
      if (writeEnable[w]) begin
        busy_nxt[writeAddr[w*AW +: AW]] = 1'b0;
      end
    end
    // A new issue is younger than any writeback this cycle.
    if (issueValid) begin
      busy_nxt[issueRd] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      busy <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      busy <= busy_nxt;
      // Later ports overwrite earlier ones on an address collision.
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (writeEnable[w] && (writeAddr[w*AW +: AW] != '0)) begin
          mem[writeAddr[w*AW +: AW]] <= writeData[w*XLEN +: XLEN];
        end
      end
    end
  end

  assign busyVector = busy;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;

    assign ra = readAddr[p*AW +: AW];

    always_comb begin
      rd = mem[ra];
      if ((BYPASS != 0) && resetN) begin
        for (int w = 0; w < WRITE_PORTS; w++) begin
          if (writeEnable[w] && (writeAddr[w*AW +: AW] == ra)) begin
            rd = writeData[w*XLEN +: XLEN];
          end
        end
      end
      if (ra == '0) begin
        rd = '0;
      end
    end

    assign readData[p*XLEN +: XLEN] = rd;
    assign readBusy[p] = (ra != '0) && busy[ra];
  end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed bench for multi_port_register_file: a bypassing and a
// non-bypassing instance share stimulus; vectors plus corner sequences.
module tb_multi_port_register_file;

  logic        clock = 1'b0;
  logic        resetN;
  logic [4:0]  ra0, ra1, wa0, wa1, ird;
  logic [31:0] wd0, wd1;
  logic [1:0]  we;
  logic        iv, fl;

  logic [9:0]  readAddr;
  logic [9:0]  writeAddr;
  logic [63:0] writeData;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic [31:0] bvec, bvec_nb;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  assign readAddr  = {ra1, ra0};
  assign writeAddr = {wa1, wa0};
  assign writeData = {wd1, wd0};

  multi_port_register_file #(.BYPASS(1)) dut (
    .clock(clock), .resetN(resetN),
    .readAddr(readAddr), .readData(rdata), .readBusy(rbusy),
    .writeEnable(we), .writeAddr(writeAddr), .writeData(writeData),
    .issueValid(iv), .issueRd(ird), .flush(fl), .busyVector(bvec)
  );

  multi_port_register_file #(.BYPASS(0)) dut_nb (
    .clock(clock), .resetN(resetN),
    .readAddr(readAddr), .readData(rdata_nb), .readBusy(rbusy_nb),
    .writeEnable(we), .writeAddr(writeAddr), .writeData(writeData),
    .issueValid(iv), .issueRd(ird), .flush(fl), .busyVector(bvec_nb)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [31:0] e_busy;
    logic [1:0]  e_rb;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic idle();
    we = 2'b00; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
    iv = 0; ird = 0; fl = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetN = 1'b0;
    ra0 = 0; ra1 = 0;
    idle();

    vecs[0] = '{2'b11, 5'd1, 32'h100, 5'd2, 32'h200, 1'b0, 5'd0, 1'b0,
                5'd1, 5'd2, 32'h100, 32'h200, 32'h0, 2'b00};
    vecs[1] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd1, 5'd2, 32'h100, 32'h200, 32'h0, 2'b00};
    vecs[2] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0,
                5'd1, 5'd2, 32'h100, 32'h200, 32'h0, 2'b00};
    vecs[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0,
                5'd1, 5'd2, 32'h100, 32'h200, 32'h2, 2'b01};
    vecs[4] = '{2'b10, 5'd0, 32'h0, 5'd1, 32'h111, 1'b0, 5'd0, 1'b0,
                5'd1, 5'd2, 32'h111, 32'h200, 32'h6, 2'b11};
    vecs[5] = '{2'b11, 5'd2, 32'h222, 5'd2, 32'h333, 1'b0, 5'd0, 1'b0,
                5'd2, 5'd1, 32'h333, 32'h111, 32'h4, 2'b01};
    vecs[6] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd2, 5'd0, 32'h333, 32'h0, 32'h0, 2'b00};
    vecs[7] = '{2'b01, 5'd0, 32'hFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0,
                5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00};
    vecs[8] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                5'd0, 5'd1, 32'h0, 32'h111, 32'h0, 2'b00};

    #12;
    resetN = 1'b1;
    #1;
    chk("reset busyVector", 64'(bvec), 64'h0);
    chk("reset readData", rdata, 64'h0);
    tick();

    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we;
      wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      iv = vecs[i].iv; ird = vecs[i].ird; fl = vecs[i].fl;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      #2;
      chk($sformatf("vec%0d rd0", i), 64'(rdata[31:0]), 64'(vecs[i].e_rd0));
      chk($sformatf("vec%0d rd1", i), 64'(rdata[63:32]), 64'(vecs[i].e_rd1));
      chk($sformatf("vec%0d busy", i), 64'(bvec), 64'(vecs[i].e_busy));
      chk($sformatf("vec%0d rbusy", i), 64'(rbusy), 64'(vecs[i].e_rb));
      tick();
    end
    idle();

    // bypass vs. array-only read of a same-cycle write
    we = 2'b01; wa0 = 5'd3; wd0 = 32'h11; ra0 = 5'd3; ra1 = 5'd3;
    #2;
    chk("bypass rd1", 64'(rdata[63:32]), 64'h11);
    chk("nobypass old rd1", 64'(rdata_nb[63:32]), 64'h0);
    tick();
    idle();
    #2;
    chk("nobypass new rd1", 64'(rdata_nb[63:32]), 64'h11);

    // write collision
    we = 2'b11; wa0 = 5'd7; wd0 = 32'hAAAA; wa1 = 5'd7; wd1 = 32'h5555;
    tick();
    idle();
    ra0 = 5'd7;
    #2;
    chk("collision bypass", 64'(rdata[31:0]), 64'h5555);
    chk("collision nobypass", 64'(rdata_nb[31:0]), 64'h5555);

    // scoreboard set beats clear
    iv = 1; ird = 5'd9; ra0 = 5'd9;
    tick();
    idle();
    tick();
    chk("sb busy9 issued", 64'(bvec[9]), 64'h1);
    we = 2'b01; wa0 = 5'd9; wd0 = 32'h99; iv = 1; ird = 5'd9;
    #2;
    chk("sb readBusy9", 64'(rbusy[0]), 64'h1);
    tick();
    idle();
    chk("sb busy9 set+clr", 64'(bvec[9]), 64'h1);
    we = 2'b10; wa1 = 5'd9; wd1 = 32'h999;
    tick();
    idle();
    #2;
    chk("sb busy9 cleared", 64'(bvec[9]), 64'h0);
    chk("sb x9 data", 64'(rdata[31:0]), 64'h999);

    // flush overrides issue, writes still land
    iv = 1; ird = 5'd4; tick();
    ird = 5'd6; tick();
    ird = 5'd8; tick();
    idle();
    chk("flush pre busy", 64'(bvec), 64'h150);
    fl = 1; iv = 1; ird = 5'd10;
    we = 2'b01; wa0 = 5'd5; wd0 = 32'h55;
    tick();
    idle();
    ra0 = 5'd5;
    #2;
    chk("flush busy", 64'(bvec), 64'h0);
    chk("flush write", 64'(rdata[31:0]), 64'h55);

    // asynchronous reset, and a write held across a reset edge
    we = 2'b01; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    tick();
    idle();
    iv = 1; ird = 5'd5;
    tick();
    idle();
    #1;
    chk("pre-reset x5", 64'(rdata[31:0]), 64'hDEADBEEF);
    chk("pre-reset busy5", 64'(bvec[5]), 64'h1);
    resetN = 1'b0;
    #1;
    chk("async reset x5", 64'(rdata[31:0]), 64'h0);
    chk("async reset busy", 64'(bvec), 64'h0);
    chk("async reset rbusy", 64'(rbusy), 64'h0);
    we = 2'b01; wa0 = 5'd6; wd0 = 32'h66; iv = 1; ird = 5'd6;
    ra1 = 5'd6;
    #1;
    chk("reset rd1 masked", 64'(rdata[63:32]), 64'h0);
    tick();
    idle();
    resetN = 1'b1;
    #2;
    chk("reset-dropped x6", 64'(rdata[63:32]), 64'h0);
    chk("reset-dropped busy", 64'(bvec), 64'h0);
    tick();
    #2;
    chk("post-reset x6", 64'(rdata_nb[63:32]), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
